vdp_scanline_buffer: RTL

Double-buffered scanline store between the VDP pixel renderer and the video output pins. Directly downstream of the raster timing generator: the renderer fills one line bank while this block scans out the other. The active bank is indexed by the generator's raster_x. Pixels, hsync, vsync and active_display all leave with one fixed, matched latency.

---
 rtl/vdp_video_pkg.sv | 18 +
 rtl/vdp_line_ram.sv | 27 ++
 rtl/vdp_scanline_buffer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vdp_video_pkg.sv
// Shared VDP video constants: default pixel format, RGB444 field positions and
// the visible-window defaults also used by the raster timing generator.
package vdp_video_pkg;

  localparam int DEF_PIXEL_WIDTH    = 12;
  localparam int DEF_H_ACTIVE_WIDTH = 848;
  localparam int DEF_ACTIVE_X_START = 240;
  localparam int RASTER_X_WIDTH     = 11;

  // RGB444 field positions inside a pixel word.
  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

endpackage

// File: rtl/vdp_line_ram.sv
// One scanline bank: simple dual-port RAM with one write port and one
// registered read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates on the clock edge only when re=1
//   rdata        : registered read data (old data on same-address collision)
module vdp_line_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vdp_scanline_buffer.sv
// Double-buffered scanline store between the pixel renderer and the video pins.
// The renderer fills write_bank while the other bank is scanned out by raster_x;
// every scanned pixel is overwritten with bg_color one cycle after it is read.
// Pixels, hsync, vsync and active_display leave with a matched 2-cycle latency
// (counting only cycles with hold_raster=0).
//   clk, reset          : pixel clock, synchronous active-high reset
//   hold_raster         : freezes bank select, output pipeline and clears
//   raster_x, hsync_in, vsync_in, active_display_in, line_ended : raster timing
//   bg_color            : clear value written back after scan-out
//   write_en/x/data     : renderer pixel writes into write_bank
//   line_swapped        : one-cycle pulse after each bank swap
//   write_bank          : bank currently accepting renderer writes
//   r, g, b, hsync, vsync, active_display : delayed video outputs
module vdp_scanline_buffer
  import vdp_video_pkg::*;
#(
  parameter int H_ACTIVE_WIDTH = DEF_H_ACTIVE_WIDTH,
  parameter int ACTIVE_X_START = DEF_ACTIVE_X_START,
  parameter int PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold_raster,
  input  logic [RASTER_X_WIDTH-1:0] raster_x,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      active_display_in,
  input  logic                      line_ended,
  input  logic [PIXEL_WIDTH-1:0]    bg_color,
  input  logic                      write_en,
  input  logic [ADDR_WIDTH-1:0]     write_x,
  input  logic [PIXEL_WIDTH-1:0]    write_data,
  output logic                      line_swapped,
  output logic                      write_bank,
  output logic [3:0]                r,
  output logic [3:0]                g,
  output logic [3:0]                b,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      active_display
);

  localparam logic [ADDR_WIDTH:0]     X_LIMIT = (ADDR_WIDTH+1)'(H_ACTIVE_WIDTH);
  localparam logic [RASTER_X_WIDTH-1:0] X_START = RASTER_X_WIDTH'(ACTIVE_X_START);

  logic                   swap;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   wr_ok;
  logic                   clr_fire;

  // Stage 1 (aligned with the RAM read register).
  logic                   act_d1;
  logic                   hs_d1;
  logic                   vs_d1;
  logic                   rd_bank_d1;
  logic                   clr_pend;
  logic [ADDR_WIDTH-1:0]  clr_addr;

  logic [PIXEL_WIDTH-1:0] bank_rdata [2];
  logic [PIXEL_WIDTH-1:0] pix;

  assign swap     = line_ended & ~hold_raster;
  assign rd_en    = active_display_in & ~hold_raster;
  assign rd_addr  = ADDR_WIDTH'(raster_x - X_START);
  assign wr_ok    = write_en & ({1'b0, write_x} < X_LIMIT);
  // A clear pending at a reset edge is discarded along with the pixel.
  assign clr_fire = clr_pend & ~hold_raster & ~reset;
  assign pix      = bank_rdata[rd_bank_d1];

  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    localparam logic BANK = 1'(gb);
    logic                   ren_hit;
    logic                   clr_hit;
    logic                   we;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [PIXEL_WIDTH-1:0] wdata;

    // Renderer and clear normally hit different banks; renderer wins if not.
    always_comb begin
      ren_hit = wr_ok && (write_bank == BANK);
      clr_hit = clr_fire && (rd_bank_d1 == BANK);
      we      = ren_hit | clr_hit;
      waddr   = ren_hit ? write_x : clr_addr;
      wdata   = ren_hit ? write_data : bg_color;
    end

    vdp_line_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(PIXEL_WIDTH)
    ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .re   (rd_en && (write_bank != BANK)),
      .raddr(rd_addr),
      .rdata(bank_rdata[gb])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_bank     <= 1'b0;
      line_swapped   <= 1'b0;
      act_d1         <= 1'b0;
      hs_d1          <= 1'b1;
      vs_d1          <= 1'b1;
      rd_bank_d1     <= 1'b1;
      clr_pend       <= 1'b0;
      clr_addr       <= '0;
      r              <= '0;
      g              <= '0;
      b              <= '0;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      active_display <= 1'b0;
    end else begin
      line_swapped <= swap;
      if (!hold_raster) begin
        if (swap) write_bank <= ~write_bank;
        // Entries entering the pipe at a swap are blanked and never cleared.
        act_d1         <= active_display_in & ~swap;
        clr_pend       <= active_display_in & ~swap;
        hs_d1          <= hsync_in;
        vs_d1          <= vsync_in;
        rd_bank_d1     <= ~write_bank;
        clr_addr       <= rd_addr;
        active_display <= act_d1;
        hsync          <= hs_d1;
        vsync          <= vs_d1;
        r              <= act_d1 ? pix[R_MSB:R_LSB] : '0;
        g              <= act_d1 ? pix[G_MSB:G_LSB] : '0;
        b              <= act_d1 ? pix[B_MSB:B_LSB] : '0;
      end
    end
  end

endmodule
